// File: rtl/max7219_rx_pkg.sv
// Shared MAX7219 register map and word type, used by both the driver and the receive-side model.
package max7219_pkg;

    typedef logic [15:0] max_word_t;

    localparam logic [3:0] REG_NOOP      = 4'h0;
    localparam logic [3:0] REG_DIGIT0    = 4'h1;
    localparam logic [3:0] REG_DIGIT1    = 4'h2;
    localparam logic [3:0] REG_DIGIT2    = 4'h3;
    localparam logic [3:0] REG_DIGIT3    = 4'h4;
    localparam logic [3:0] REG_DIGIT4    = 4'h5;
    localparam logic [3:0] REG_DIGIT5    = 4'h6;
    localparam logic [3:0] REG_DIGIT6    = 4'h7;
    localparam logic [3:0] REG_DIGIT7    = 4'h8;
    localparam logic [3:0] REG_DECODE    = 4'h9;
    localparam logic [3:0] REG_INTENSITY = 4'hA;
    localparam logic [3:0] REG_SCANLIMIT = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
    localparam logic [3:0] REG_TEST      = 4'hF;

    localparam logic [4:0] WORD_BITS = 5'd16;
    localparam logic [4:0] CNT_MAX   = 5'd31;

    function automatic logic [3:0] word_addr(input max_word_t w);
        return w[11:8];
    endfunction

endpackage

// File: rtl/max7219_rx_if.sv
// Three-wire MAX7219 serial link plus the daisy-chain return line.
interface max7219_rx_if;
    logic spi_clk;
    logic spi_din;
    logic spi_load;
    logic spi_dout;

    modport master (output spi_clk, output spi_din, output spi_load, input spi_dout);
    modport slave  (input spi_clk, input spi_din, input spi_load, output spi_dout);
endinterface

// File: rtl/max7219_rx_sync_edge.sv
// Multi-stage synchronizer with a previous-value flop and registered edge strobes.
module sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            level <= chain[STAGES-1];
            rise  <= chain[STAGES-1] & ~level;
            fall  <= ~chain[STAGES-1] & level;
        end
    end

endmodule

// File: rtl/max7219_rx.sv
// Receive-side MAX7219 model: oversamples DIN/CLK/LOAD, assembles 16-bit words and keeps the shadow registers.
module max7219_rx
    import max7219_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    max7219_rx_if.slave       spi,
    output logic [63:0]       digits,
    output logic [7:0]        decode_mode,
    output logic [3:0]        intensity,
    output logic [2:0]        scan_limit,
    output logic              shutdown,
    output logic              display_test,
    output logic              word_valid,
    output max_word_t         word,
    output logic              overrun,
    output logic              short_word
);

    logic clk_level, clk_rise, clk_fall;
    logic load_level, load_rise, load_fall;
    logic din_level, din_rise, din_fall;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
        .clk(clk), .reset_n(reset_n), .d(spi.spi_clk),
        .level(clk_level), .rise(clk_rise), .fall(clk_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_load (
        .clk(clk), .reset_n(reset_n), .d(spi.spi_load),
        .level(load_level), .rise(load_rise), .fall(load_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_din (
        .clk(clk), .reset_n(reset_n), .d(spi.spi_din),
        .level(din_level), .rise(din_rise), .fall(din_fall)
    );

    logic unused_edges;
    assign unused_edges = &{1'b0, clk_level, din_rise, din_fall};

    max_word_t  sr;
    logic [4:0] bit_cnt;
    logic       dout_q;
    logic [3:0] addr;
    logic [7:0] data;
    logic [3:0] dig_sel;

    assign addr    = word_addr(sr);
    assign data    = sr[7:0];
    assign dig_sel = addr - 4'd1;
    assign spi.spi_dout = dout_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr           <= '0;
            bit_cnt      <= '0;
            dout_q       <= 1'b0;
            digits       <= '0;
            decode_mode  <= '0;
            intensity    <= '0;
            scan_limit   <= '0;
            shutdown     <= 1'b1;
            display_test <= 1'b0;
            word_valid   <= 1'b0;
            word         <= '0;
            overrun      <= 1'b0;
            short_word   <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clk_fall) begin
                dout_q <= sr[15];
            end
            // load_level is already high on the rise cycle, so it also masks a coincident clock edge
            if (load_rise) begin
                bit_cnt <= '0;
                if (bit_cnt >= WORD_BITS) begin
                    word_valid <= 1'b1;
                    word       <= sr;
                    if (bit_cnt > WORD_BITS) begin
                        overrun <= 1'b1;
                    end
                    case (addr)
                        REG_DIGIT0, REG_DIGIT1, REG_DIGIT2, REG_DIGIT3,
                        REG_DIGIT4, REG_DIGIT5, REG_DIGIT6, REG_DIGIT7:
                            digits[{dig_sel[2:0], 3'b000} +: 8] <= data;
                        REG_DECODE:    decode_mode  <= data;
                        REG_INTENSITY: intensity    <= data[3:0];
                        REG_SCANLIMIT: scan_limit   <= data[2:0];
                        REG_SHUTDOWN:  shutdown     <= ~data[0];
                        REG_TEST:      display_test <= data[0];
                        default: ;
                    endcase
                end else begin
                    short_word <= 1'b1;
                end
            end else if (load_fall) begin
                bit_cnt <= '0;
            end else if (clk_rise && !load_level) begin
                sr <= {sr[14:0], din_level};
                if (bit_cnt != CNT_MAX) begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_max7219_rx.sv
// Randomized bench for max7219_rx against a delayed-sample protocol model of the MAX7219 receiver.
module tb_max7219_rx;
    import max7219_pkg::*;

    localparam int unsigned S = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    max7219_rx_if spi ();

    logic [63:0] digits;
    logic [7:0]  decode_mode;
    logic [3:0]  intensity;
    logic [2:0]  scan_limit;
    logic        shutdown, display_test, word_valid, overrun, short_word;
    max_word_t   word;

    max7219_rx #(.SYNC_STAGES(S)) dut (
        .clk(clk), .reset_n(reset_n), .spi(spi),
        .digits(digits), .decode_mode(decode_mode), .intensity(intensity),
        .scan_limit(scan_limit), .shutdown(shutdown), .display_test(display_test),
        .word_valid(word_valid), .word(word), .overrun(overrun), .short_word(short_word)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int vcount = 0;
    logic [15:0] cap;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_digit [8];
    logic [7:0] m_decode;
    logic [3:0] m_int;
    logic [2:0] m_scan;
    logic       m_shut, m_test, m_valid, m_dout, m_ovr, m_short;
    logic [15:0] m_word;
    int         m_cnt;
    logic       m_hist[$];
    logic       hc[$], hl[$], hd[$];

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_digit[i] = 8'h00;
        m_decode = 0; m_int = 0; m_scan = 0; m_shut = 1; m_test = 0;
        m_valid = 0; m_dout = 0; m_ovr = 0; m_short = 0; m_word = 0; m_cnt = 0;
        m_hist.delete(); hc.delete(); hl.delete(); hd.delete();
        for (int i = 0; i < S + 3; i++) begin
            hc.push_back(1'b0); hl.push_back(1'b0); hd.push_back(1'b0);
        end
    endtask

    task automatic model_commit(input logic [15:0] w);
        int a;
        a = int'(w[11:8]);
        m_valid = 1; m_word = w;
        if (a >= 1 && a <= 8) m_digit[a-1] = w[7:0];
        else if (a == 9)  m_decode = w[7:0];
        else if (a == 10) m_int = w[3:0];
        else if (a == 11) m_scan = w[2:0];
        else if (a == 12) m_shut = ~w[0];
        else if (a == 15) m_test = w[0];
    endtask

    // An input change becomes visible to the receive logic S+1 clk edges after it is first sampled.
    initial begin
        logic c_now, c_old, l_now, l_old, d_now;
        logic [15:0] w;
        model_reset();
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                model_reset();
            end else begin
                hc.push_front(spi.spi_clk);  void'(hc.pop_back());
                hl.push_front(spi.spi_load); void'(hl.pop_back());
                hd.push_front(spi.spi_din);  void'(hd.pop_back());
                c_now = hc[S+1]; c_old = hc[S+2];
                l_now = hl[S+1]; l_old = hl[S+2];
                d_now = hd[S+1];
                m_valid = 0;
                if (!c_now && c_old)
                    m_dout = (m_hist.size() >= 16) ? m_hist[m_hist.size()-16] : 1'b0;
                if (l_now && !l_old) begin
                    if (m_cnt >= 16) begin
                        for (int i = 0; i < 16; i++) w[15-i] = m_hist[m_hist.size()-16+i];
                        model_commit(w);
                        if (m_cnt > 16) m_ovr = 1;
                    end else begin
                        m_short = 1;
                    end
                    m_cnt = 0;
                end else if (!l_now && l_old) begin
                    m_cnt = 0;
                end else if (c_now && !c_old && !l_now) begin
                    m_hist.push_back(d_now);
                    if (m_hist.size() > 16) void'(m_hist.pop_front());
                    if (m_cnt < 31) m_cnt++;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [63:0] exp_dig;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) exp_dig[8*i +: 8] = m_digit[i];
            chk("digits", digits, exp_dig);
            chk("ctrl_regs", {44'd0, decode_mode, intensity, scan_limit, shutdown, display_test},
                             {44'd0, m_decode, m_int, m_scan, m_shut, m_test});
            chk("word", {47'd0, word_valid, word}, {47'd0, m_valid, m_word});
            chk("flags_dout", {61'd0, overrun, short_word, spi.spi_dout},
                              {61'd0, m_ovr, m_short, m_dout});
            if (word_valid === 1'b1) vcount++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_bits(input int n, input logic [31:0] val);
        int h;
        for (int i = n - 1; i >= 0; i--) begin
            h = int'($urandom_range(S + 2, S + 5));
            @(negedge clk);
            spi.spi_din = val[i];
            repeat (h) @(negedge clk);
            cap = {cap[14:0], spi.spi_dout};
            spi.spi_clk = 1'b1;
            repeat (h) @(negedge clk);
            spi.spi_clk = 1'b0;
        end
    endtask

    task automatic frame(input int n, input logic [31:0] val);
        cap = '0;
        @(negedge clk);
        spi.spi_load = 1'b0;
        repeat (S + 4) @(negedge clk);
        send_bits(n, val);
        repeat (S + 4) @(negedge clk);
        spi.spi_load = 1'b1;
        repeat (S + 6) @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int v0, n;
        logic [31:0] r;
        spi.spi_clk = 0; spi.spi_din = 0; spi.spi_load = 0;
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("reset_shutdown", shutdown, 1);
        chk("reset_word", word, 0);

        v0 = vcount;
        frame(16, 32'h0C01); chk("t1_shutdown_on", shutdown, 0);
        frame(16, 32'h0A07);
        frame(16, 32'h0B07);
        chk("t1_intensity", intensity, 7);
        chk("t1_scan", scan_limit, 7);
        chk("t1_pulses", vcount - v0, 3);

        frame(16, 32'h0155); frame(16, 32'h08AA); frame(16, 32'h0900);
        chk("t2_dig0", digits[7:0], 8'h55);
        chk("t2_dig7", digits[63:56], 8'hAA);
        chk("t2_mid", digits[55:8], 0);
        chk("t2_decode", decode_mode, 0);

        frame(20, 32'hF0F3C);
        chk("t3_word", word, 16'h0F3C);
        chk("t3_test", display_test, 0);
        chk("t3_overrun", overrun, 1);

        v0 = vcount;
        frame(12, $urandom);
        chk("t4_no_pulse", vcount - v0, 0);
        chk("t4_short", short_word, 1);
        chk("t4_intensity_kept", intensity, 7);
        frame(16, 32'h0A03);
        chk("t4_intensity", intensity, 3);

        v0 = vcount;
        frame(16, 32'h0D12);
        chk("t5_word1", word, 16'h0D12);
        frame(16, 32'h0000);
        chk("t5_pulses", vcount - v0, 2);
        chk("t5_word2", word, 16'h0000);
        chk("t5_dout", cap, 16'h0D12);

        for (int k = 0; k < 40; k++) begin
            r = $urandom;
            case ($urandom_range(0, 7))
                0:       n = int'($urandom_range(17, 22));
                1:       n = int'($urandom_range(1, 15));
                default: n = 16;
            endcase
            frame(n, r);
        end

        @(negedge clk);
        spi.spi_load = 1'b0;
        repeat (S + 4) @(negedge clk);
        send_bits(8, 32'h0C);
        @(negedge clk);
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_shutdown", shutdown, 1);
        chk("rst_flags", {overrun, short_word, word_valid}, 0);
        chk("rst_digits", digits, 0);
        chk("rst_word", word, 0);
        #2 reset_n = 1'b1;
        frame(16, 32'h0C01);
        chk("rst_after_shutdown", shutdown, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
